// File: rtl/data_mem_access_unit.sv
// rtl/data_mem_access_unit.sv - byte/half/word load-store front end to a word-wide data RAM.
// Optional range check on upper address bits: define DMAU_BOUNDS_CHECK_EN.
module data_mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic                  unsigned_ld,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t                  state, state_next;
  logic                    wr_q, uns_q, fault_q;
  logic [1:0]              size_q;
  logic [ADDR_WIDTH+1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, buf_q, rdata_q;
  logic                    req_fault, accept, partial;
  logic [4:0]              shamt;
  logic [DATA_WIDTH-1:0]   lane_mask, merged, shifted, extracted;
  logic                    unused_addr_bits;

  assign accept  = req && (state == IDLE);
  assign partial = (size_q != 2'b10);

  always_comb begin
    req_fault = (size == 2'b11) ||
                (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00);
`ifdef DMAU_BOUNDS_CHECK_EN
    req_fault = req_fault || (addr[31:ADDR_WIDTH+2] != '0);
`endif
  end

  // Upper address bits only matter when the range check is built in.
  assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req) begin
        if (req_fault)           state_next = RESP;
        else if (!wr)            state_next = RD;
        else if (size == 2'b10)  state_next = WR;
        else                     state_next = RD;
      end
      RD:      state_next = wr_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready  = (state == IDLE);
    done   = (state == RESP);
    ram_we = (state == WR);
    fault  = (state == RESP) && fault_q;
  end

  // Little-endian lane select: shift the addressed lane down to bit 0.
  always_comb begin
    shamt   = {addr_q[1:0], 3'b000};
    shifted = ram_q >> shamt;
    case (size_q)
      2'b00:   extracted = {{24{shifted[7]  && !uns_q}}, shifted[7:0]};
      2'b01:   extracted = {{16{shifted[15] && !uns_q}}, shifted[15:0]};
      default: extracted = ram_q;
    endcase
    lane_mask = (size_q == 2'b00) ? (32'h0000_00FF << shamt) : (32'h0000_FFFF << shamt);
    merged    = (ram_q & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        wr_q    <= wr;
        uns_q   <= unsigned_ld;
        fault_q <= req_fault;
        size_q  <= size;
        addr_q  <= addr[ADDR_WIDTH+1:0];
        wdata_q <= wdata;
        buf_q   <= wdata;
      end
      if (state == RD) begin
        if (wr_q && partial) buf_q   <= merged;
        else if (!wr_q)      rdata_q <= extracted;
      end
    end
  end

  assign rdata    = rdata_q;
  assign ram_addr = addr_q[ADDR_WIDTH+1:2];
  assign ram_data = buf_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb/tb_data_mem_access_unit.sv - scoreboard bench with a behavioural memory model and negedge-write RAM.
module tb_data_mem_access_unit;

  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req = 1'b0, wr = 1'b0, unsigned_ld = 1'b0;
  logic [1:0]    size = 2'b00;
  logic [31:0]   addr = '0, wdata = '0;
  logic          ready, done, fault, ram_we;
  logic [31:0]   rdata, ram_data, ram_q;
  logic [AW-1:0] ram_addr;

  data_mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .fault(fault),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [DEPTH];
  logic [31:0] mem_ref [DEPTH];
  int          we_cnt = 0, exp_we = 0;
  assign ram_q = ram[ram_addr];
  always @(negedge clk) if (ram_we) begin
    ram[ram_addr] <= ram_data;
    we_cnt++;
  end

  typedef struct {
    logic        f;
    logic [31:0] rd;
    int          lat;
    int          acc;
  } exp_t;
  exp_t        sb[$];
  int          n_cmp = 0, n_err = 0, edge_cnt = 0;
  logic [31:0] rdata_ref = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    edge_cnt++;
    #1;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL done_unexpected: got done=1 expected no pending access at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("fault", {31'b0, fault}, {31'b0, e.f});
        chk("rdata", rdata, e.rd);
        chk("latency", edge_cnt + 1 - e.acc, e.lat);
      end
    end
  end

  // Reference: applies the access to mem_ref from the address/size rules directly.
  task automatic model(input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic        f;
    int          wi, bl;
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] h;
    f = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`ifdef DMAU_BOUNDS_CHECK_EN
    f = f || (a[31:AW+2] != '0);
`endif
    wi   = int'(a[AW+1:2]);
    bl   = int'(a[1:0]);
    word = mem_ref[wi];
    if (!f) begin
      if (w) begin
        exp_we++;
        case (sz)
          2'd0:    word[8*bl +: 8]        = d[7:0];
          2'd1:    word[16*(bl/2) +: 16]  = d[15:0];
          default: word                   = d;
        endcase
        mem_ref[wi] = word;
      end else begin
        b = word[8*bl +: 8];
        h = word[16*(bl/2) +: 16];
        case (sz)
          2'd0:    rdata_ref = u ? {24'h0, b} : {{24{b[7]}}, b};
          2'd1:    rdata_ref = u ? {16'h0, h} : {{16{h[15]}}, h};
          default: rdata_ref = word;
        endcase
      end
    end
    e.f   = f;
    e.rd  = rdata_ref;
    e.lat = f ? 1 : ((w && sz != 2'd2) ? 3 : 2);
    e.acc = edge_cnt + 1;
    sb.push_back(e);
  endtask

  // Called #1 after a posedge; holds req until the DUT is idle, then lets it be accepted.
  task automatic issue(input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] d);
    bit ok = 0;
    req = 1'b1; wr = w; size = sz; unsigned_ld = u; addr = a; wdata = d;
    for (int k = 0; k < 50; k++) begin
      if (ready) begin
        model(w, sz, u, a, d);
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 50; k++) begin
      if (ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] s0, s1, s4, s2;
    int          w0;
    bit          ok;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = $urandom;
      mem_ref[i] = ram[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("rst_ram_addr", {27'b0, ram_addr}, 32'd0);
    chk("rst_ram_data", ram_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    w0 = we_cnt;
    issue(1, 2'd2, 0, 32'h8, 32'hDEADBEEF); wait_idle();
    chk("t1_word2", ram[2], 32'hDEADBEEF);
    chk("t1_we_cycles", we_cnt - w0, 32'd1);

    issue(1, 2'd0, 0, 32'h9, 32'h0000_00A5); wait_idle();
    chk("t2_word2", ram[2], 32'hDEADA5EF);
    issue(0, 2'd0, 0, 32'h9, 32'h0); wait_idle();
    chk("t2_lb", rdata, 32'hFFFFFFA5);
    issue(0, 2'd0, 1, 32'h9, 32'h0); wait_idle();
    chk("t2_lbu", rdata, 32'h000000A5);

    issue(0, 2'd1, 0, 32'hA, 32'h0); wait_idle();
    chk("t3_lh", rdata, 32'hFFFFDEAD);
    issue(0, 2'd1, 1, 32'hA, 32'h0); wait_idle();
    chk("t3_lhu", rdata, 32'h0000DEAD);

    w0 = we_cnt; s0 = ram[0]; s1 = ram[1]; s4 = ram[4];
    issue(0, 2'd2, 0, 32'h6, 32'h0);
    issue(1, 2'd1, 0, 32'h3, 32'h1234_5678);
    issue(1, 2'd3, 0, 32'h10, 32'hCAFE_F00D);
    wait_idle();
    chk("t4_no_we", we_cnt - w0, 32'd0);
    chk("t4_word0", ram[0], s0);
    chk("t4_word1", ram[1], s1);
    chk("t4_word4", ram[4], s4);

    s0 = ram[0];
    issue(1, 2'd2, 0, 32'h80, 32'h1357_9BDF); wait_idle();
`ifdef DMAU_BOUNDS_CHECK_EN
    chk("t6_word0_kept", ram[0], s0);
`else
    chk("t6_word0_wrap", ram[0], 32'h1357_9BDF);
`endif

    // Abort a byte store by reset while in WR, before the negedge commit.
    s2 = ram[2];
    req = 1'b1; wr = 1'b1; size = 2'd0; unsigned_ld = 1'b0; addr = 32'h9; wdata = 32'h11;
    @(posedge clk); #1;
    req = 1'b0;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      if (ram_we) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("t5_reached_wr", {31'b0, ok}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_we_drop", {31'b0, ram_we}, 32'd0);
    chk("t5_ready", {31'b0, ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdata_ref = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_ram_kept", ram[2], s2);
    chk("t5_rdata_clr", rdata, 32'd0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a = ($urandom_range(0, 7) == 0) ? $urandom : {25'b0, 7'($urandom)};
      if ($urandom_range(0, 3) != 0) a[1:0] = ($urandom_range(0, 1) != 0) ? 2'b00 : a[1:0];
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(1'($urandom), sz, 1'($urandom), a, $urandom);
    end
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) chk($sformatf("final_word%0d", i), ram[i], mem_ref[i]);
    chk("final_we_count", we_cnt, exp_we);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
